// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-stage controller between the execute/memory and memory/writeback
// pipeline registers. Issues loads and stores to a multi-cycle data memory
// over a request/stall/done handshake and blocks misaligned (odd-address)
// accesses. It freezes the pipeline while an access is outstanding and gives
// up on an access that stays in BUSY for TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT       cycles allowed in BUSY before the access is abandoned (1..255)
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   XM_aluOut     effective address           -> mem_addr (pass-through)
//   XM_writeData  store data                  -> mem_data_in (pass-through)
//   XM_memRead    instruction is a load (wins when both read and write are set)
//   XM_memWrite   instruction is a store
//   XM_flush      instruction is squashed; no access is made
//   mem_rd/mem_wr read / write request strobes
//   mem_data_out  memory read data, valid with mem_done
//   mem_stall     memory did not accept this cycle's request
//   mem_done      access complete
//   readData      load result (zero unless a read completes this cycle)
//   stall_m       freezes PC and all pipeline registers
//   align_err_m   misaligned access detected
//   timeout_err   one-cycle pulse when an access is abandoned
//   busy          high while the FSM is in BUSY
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] XM_aluOut,
  input  logic [15:0] XM_writeData,
  input  logic        XM_memRead,
  input  logic        XM_memWrite,
  input  logic        XM_flush,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_stall,
  input  logic        mem_done,
  output logic [15:0] readData,
  output logic        stall_m,
  output logic        align_err_m,
  output logic        timeout_err,
  output logic        busy
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_cnt;
  logic [7:0] w_nextCnt;
  logic       r_rdPend;
  logic       w_nextRdPend;

  logic       w_acc;
  logic       w_mis;
  logic       w_req;
  logic       w_timedOut;

  // Request decode: a squashed instruction makes no access, and an odd
  // address turns an access into an alignment error instead of a request.
  assign w_acc      = (XM_memRead | XM_memWrite) & ~XM_flush;
  assign w_mis      = w_acc & XM_aluOut[0];
  assign w_req      = w_acc & ~w_mis;
  assign w_timedOut = ~mem_done & (r_cnt == LP_TIMEOUT);

  assign mem_addr    = XM_aluOut;
  assign mem_data_in = XM_writeData;
  assign busy        = (r_state == ST_BUSY);

  // State register: FSM state, BUSY cycle counter and the captured
  // read/write direction of the outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_rdPend <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      r_rdPend <= w_nextRdPend;
    end
  end

  // Next-state logic. A request that the memory accepted but did not finish
  // moves to BUSY with the counter at 1; BUSY leaves on done or when the
  // counter reaches TIMEOUT.
  always_comb begin
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;
    w_nextRdPend = r_rdPend;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !mem_stall && !mem_done) begin
          w_nextState  = ST_BUSY;
          w_nextCnt    = 8'd1;
          w_nextRdPend = XM_memRead;
        end
      end
      ST_BUSY: begin
        if (mem_done || w_timedOut) begin
          w_nextState = ST_IDLE;
          w_nextCnt   = 8'd0;
        end else begin
          w_nextCnt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = 8'd0;
      end
    endcase
  end

  // Output logic. In IDLE the strobe is driven every cycle the request is
  // pending, so a request refused via mem_stall is simply re-driven. In BUSY
  // the upstream inputs are frozen, so only the captured direction matters.
  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    readData    = 16'd0;
    stall_m     = 1'b0;
    align_err_m = 1'b0;
    timeout_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mem_rd      = w_req & XM_memRead;
        mem_wr      = w_req & ~XM_memRead;
        stall_m     = w_req & ~mem_done;
        align_err_m = w_mis;
        if (w_req && XM_memRead && mem_done) begin
          readData = mem_data_out;
        end
      end
      ST_BUSY: begin
        stall_m     = ~mem_done & ~w_timedOut;
        timeout_err = w_timedOut;
        if (mem_done && r_rdPend) begin
          readData = mem_data_out;
        end
      end
      default: begin
        stall_m = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage (built with TIMEOUT = 4). Directed steps
// walk through hit, miss, misalignment, refused request, timeout and reset
// during BUSY; a randomized section then drives random instructions and
// random memory handshakes. Every cycle all outputs are compared with a
// transaction-level reference model of the outstanding access.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [15:0] XM_aluOut;
  logic [15:0] XM_writeData;
  logic        XM_memRead;
  logic        XM_memWrite;
  logic        XM_flush;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_data_out;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] readData;
  logic        stall_m;
  logic        align_err_m;
  logic        timeout_err;
  logic        busy;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: is an access outstanding, was it a load, and how many
  // cycles have elapsed since the memory accepted it.
  bit mPending  = 1'b0;
  bit mPendRead = 1'b0;
  int mAge      = 0;
  bit mLastStall = 1'b0;

  // Per-scenario tallies of what the DUT actually did.
  int stallCnt, busyCnt, rdCnt, wrCnt, toCnt;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .XM_aluOut    (XM_aluOut),
    .XM_writeData (XM_writeData),
    .XM_memRead   (XM_memRead),
    .XM_memWrite  (XM_memWrite),
    .XM_flush     (XM_flush),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out),
    .mem_stall    (mem_stall),
    .mem_done     (mem_done),
    .readData     (readData),
    .stall_m      (stall_m),
    .align_err_m  (align_err_m),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input string name, input logic obs, input logic exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s %s: observed %0b expected %0b", tag, name, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input string name, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s %s: observed %h expected %h", tag, name, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input string name, input int obs, input int exp);
    testsRun++;
    assert (obs == exp) else begin
      failCount++;
      $error("[TB] FAIL %s %s: observed %0d expected %0d", tag, name, obs, exp);
    end
  endtask

  task automatic clearCounts();
    stallCnt = 0;
    busyCnt  = 0;
    rdCnt    = 0;
    wrCnt    = 0;
    toCnt    = 0;
  endtask

  // Drive one cycle's inputs at the falling edge.
  task automatic applyStimulus(input logic r, input logic w, input logic f,
                               input logic [15:0] a, input logic [15:0] wd,
                               input logic ms, input logic md, input logic [15:0] dout);
    @(negedge clk);
    XM_memRead   = r;
    XM_memWrite  = w;
    XM_flush     = f;
    XM_aluOut    = a;
    XM_writeData = wd;
    mem_stall    = ms;
    mem_done     = md;
    mem_data_out = dout;
  endtask

  // Predict this cycle's outputs from the model, compare, then advance the
  // model to what the coming rising edge will do.
  task automatic checkOutput(input string tag);
    bit acc, mis, req;
    logic eRd, eWr, eStall, eAlign, eTo, eBusy;
    logic [15:0] eData;
    #1;
    if (rst) begin
      mPending = 1'b0;
      mAge     = 0;
    end
    acc    = (XM_memRead || XM_memWrite) && !XM_flush;
    mis    = acc && XM_aluOut[0];
    req    = acc && !mis;
    eRd    = 1'b0;
    eWr    = 1'b0;
    eStall = 1'b0;
    eAlign = 1'b0;
    eTo    = 1'b0;
    eBusy  = mPending;
    eData  = 16'd0;
    if (!mPending) begin
      eRd    = req && XM_memRead;
      eWr    = req && !XM_memRead;
      eAlign = mis;
      eStall = req && !mem_done;
      if (req && XM_memRead && mem_done) eData = mem_data_out;
    end else begin
      if (mem_done) begin
        if (mPendRead) eData = mem_data_out;
      end else if (mAge >= TO) begin
        eTo = 1'b1;
      end else begin
        eStall = 1'b1;
      end
    end

    checkWord(tag, "mem_addr",    mem_addr,    XM_aluOut);
    checkWord(tag, "mem_data_in", mem_data_in, XM_writeData);
    checkBit (tag, "mem_rd",      mem_rd,      eRd);
    checkBit (tag, "mem_wr",      mem_wr,      eWr);
    checkWord(tag, "readData",    readData,    eData);
    checkBit (tag, "stall_m",     stall_m,     eStall);
    checkBit (tag, "align_err_m", align_err_m, eAlign);
    checkBit (tag, "timeout_err", timeout_err, eTo);
    checkBit (tag, "busy",        busy,        eBusy);

    if (stall_m)     stallCnt++;
    if (busy)        busyCnt++;
    if (mem_rd)      rdCnt++;
    if (mem_wr)      wrCnt++;
    if (timeout_err) toCnt++;
    mLastStall = eStall;

    if (!rst) begin
      if (!mPending) begin
        if (req && !mem_done && !mem_stall) begin
          mPending  = 1'b1;
          mPendRead = XM_memRead;
          mAge      = 1;
        end
      end else if (mem_done || mAge >= TO) begin
        mPending = 1'b0;
      end else begin
        mAge++;
      end
    end
  endtask

  initial begin
    logic        rR, rW, rF;
    logic [15:0] rA, rWd;

    rst          = 1'b1;
    XM_aluOut    = 16'd0;
    XM_writeData = 16'd0;
    XM_memRead   = 1'b0;
    XM_memWrite  = 1'b0;
    XM_flush     = 1'b0;
    mem_data_out = 16'd0;
    mem_stall    = 1'b0;
    mem_done     = 1'b0;

    // Reset state with no access requested.
    applyStimulus(0, 0, 0, 16'h1234, 16'h5678, 0, 0, 16'h0);
    checkOutput("reset");
    rst = 1'b0;

    // Aligned load hit: completes in the request cycle.
    clearCounts();
    applyStimulus(1, 0, 0, 16'h0010, 16'h0, 0, 1, 16'hBEEF);
    checkOutput("loadHit");
    checkWord("loadHit", "readDataDirect", readData, 16'hBEEF);
    applyStimulus(0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h0);
    checkOutput("loadHitIdle");
    checkCount("loadHit", "stallCycles", stallCnt, 0);
    checkCount("loadHit", "rdCycles", rdCnt, 1);

    // Store miss: done 3 cycles after acceptance.
    clearCounts();
    applyStimulus(0, 1, 0, 16'h0020, 16'hA5A5, 0, 0, 16'h0);
    checkOutput("storeMiss0");
    for (int i = 1; i < 3; i++) begin
      applyStimulus(0, 1, 0, 16'h0020, 16'hA5A5, 0, 0, 16'h0);
      checkOutput("storeMissWait");
    end
    applyStimulus(0, 1, 0, 16'h0020, 16'hA5A5, 0, 1, 16'hFFFF);
    checkOutput("storeMissDone");
    checkCount("storeMiss", "stallCycles", stallCnt, 3);
    checkCount("storeMiss", "busyCycles", busyCnt, 3);
    checkCount("storeMiss", "wrCycles", wrCnt, 1);

    // Misaligned load.
    clearCounts();
    applyStimulus(1, 0, 0, 16'h0021, 16'h0, 0, 1, 16'hCAFE);
    checkOutput("misaligned");
    checkBit("misaligned", "alignDirect", align_err_m, 1'b1);
    checkCount("misaligned", "rdCycles", rdCnt, 0);

    // Load refused twice by mem_stall, then accepted, done one cycle later.
    clearCounts();
    applyStimulus(1, 0, 0, 16'h0030, 16'h0, 1, 0, 16'h0);
    checkOutput("refused0");
    applyStimulus(1, 0, 0, 16'h0030, 16'h0, 1, 0, 16'h0);
    checkOutput("refused1");
    applyStimulus(1, 0, 0, 16'h0030, 16'h0, 0, 0, 16'h0);
    checkOutput("accepted");
    applyStimulus(1, 0, 0, 16'h0030, 16'h0, 0, 1, 16'h1234);
    checkOutput("refusedDone");
    checkWord("refusedDone", "readDataDirect", readData, 16'h1234);
    checkCount("refused", "rdCycles", rdCnt, 3);
    checkCount("refused", "stallCycles", stallCnt, 3);

    // Load that never completes: abandoned after TIMEOUT stalled cycles.
    clearCounts();
    for (int i = 0; i < TO + 1; i++) begin
      applyStimulus(1, 0, 0, 16'h0040, 16'h0, 0, 0, 16'h7777);
      checkOutput("timeout");
    end
    checkBit("timeout", "pulseDirect", timeout_err, 1'b1);
    applyStimulus(0, 0, 0, 16'h0040, 16'h0, 0, 0, 16'h0);
    checkOutput("timeoutIdle");
    checkCount("timeout", "stallCycles", stallCnt, TO);
    checkCount("timeout", "pulseCycles", toCnt, 1);

    // Reset asserted in the middle of BUSY.
    clearCounts();
    applyStimulus(0, 1, 0, 16'h0050, 16'h1111, 0, 0, 16'h0);
    checkOutput("rstAccept");
    applyStimulus(0, 1, 0, 16'h0050, 16'h1111, 0, 0, 16'h0);
    checkOutput("rstBusy");
    @(negedge clk);
    #2;
    rst         = 1'b1;
    XM_memWrite = 1'b0;
    #1;
    checkBit("rstMidBusy", "busy", busy, 1'b0);
    checkBit("rstMidBusy", "stall_m", stall_m, 1'b0);
    mPending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clearCounts();
    applyStimulus(1, 0, 0, 16'h0060, 16'h0, 0, 0, 16'h0);
    checkOutput("afterRst0");
    applyStimulus(1, 0, 0, 16'h0060, 16'h0, 0, 0, 16'h0);
    checkOutput("afterRst1");
    applyStimulus(1, 0, 0, 16'h0060, 16'h0, 0, 1, 16'h5A5A);
    checkOutput("afterRstDone");
    checkCount("afterRst", "stallCycles", stallCnt, 2);

    // Randomized traffic: a new instruction only when the pipeline moved.
    rR = 1'b0; rW = 1'b0; rF = 1'b0; rA = 16'h0; rWd = 16'h0;
    mLastStall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!mLastStall) begin
        rR  = 1'($urandom_range(0, 1));
        rW  = 1'($urandom_range(0, 1));
        rF  = ($urandom_range(0, 99) < 15);
        rA  = 16'($urandom);
        rWd = 16'($urandom);
        if ($urandom_range(0, 3) != 0) rA[0] = 1'b0;
      end
      applyStimulus(rR, rW, rF, rA, rWd,
                    ($urandom_range(0, 99) < 40),
                    ($urandom_range(0, 99) < 35),
                    16'($urandom));
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-stage controller between the execute/memory pipeline register and the memory/writeback pipeline register. It issues loads and stores to a multi-cycle data memory using a request/stall/done handshake, and blocks misaligned accesses. It freezes the pipeline while an access is outstanding and produces the load data and alignment error consumed by the memory/writeback register.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent in BUSY before the access is abandoned (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- XM_aluOut  in  16  effective address.
- XM_writeData  in  16  store data.
- XM_memRead  in  1  instruction is a load.
- XM_memWrite  in  1  instruction is a store.
- XM_flush  in  1  instruction is squashed; it performs no access.
- mem_addr  out  16  memory address; always equal to XM_aluOut.
- mem_data_in  out  16  memory write data; always equal to XM_writeData.
- mem_rd  out  1  read request strobe.
- mem_wr  out  1  write request strobe.
- mem_data_out  in  16  memory read data; valid when mem_done is high.
- mem_stall  in  1  memory is busy and did not accept this cycle's request.
- mem_done  in  1  access complete.
- readData  out  16  load result to the memory/writeback register.
- stall_m  out  1  freezes the PC and all pipeline registers.
- align_err_m  out  1  misaligned access detected.
- timeout_err  out  1  one-cycle pulse when an access is abandoned.
- busy  out  1  high when state is BUSY.

## Operation
- Access request: acc = (XM_memRead | XM_memWrite) & ~XM_flush.
- Misaligned: mis = acc & XM_aluOut[0].
- Valid request: req = acc & ~mis.
- When XM_memRead and XM_memWrite are both high, the access is treated as a read.
- The FSM has two states, IDLE and BUSY, plus an 8-bit counter cnt.
- IDLE behaviour:
  - mem_rd = req & XM_memRead; mem_wr = req & ~XM_memRead.
  - req & mem_done: the access completes in the same cycle; stall_m = 0; state stays IDLE.
  - req & mem_stall & ~mem_done: request not accepted; stall_m = 1; state stays IDLE and the request is re-driven next cycle.
  - req & ~mem_stall & ~mem_done: request accepted; stall_m = 1; go to BUSY with cnt = 1.
  - mis: no strobe; align_err_m = 1; stall_m = 0; readData = 0.
- BUSY behaviour:
  - mem_rd = mem_wr = 0; inputs are frozen upstream, and XM_flush is ignored.
  - mem_done: stall_m = 0; go to IDLE with cnt = 0.
  - ~mem_done & cnt == TIMEOUT: stall_m = 0; timeout_err = 1; readData = 0; go to IDLE.
  - Otherwise: stall_m = 1; cnt increments.
- readData = mem_data_out when mem_done is high and a read is in progress (IDLE with req & XM_memRead, or BUSY with the read captured at acceptance). Otherwise readData = 0.
- A 1-bit register rd_pend captures XM_memRead when BUSY is entered.
- mem_done in IDLE with no req is ignored.

## Timing
- Reset (asynchronous, immediate): state = IDLE, cnt = 0, rd_pend = 0. With acc = 0, every output is 0 except mem_addr and mem_data_in, which pass their inputs through.
- Reset during BUSY aborts the access. Memory shares rst, so no late mem_done occurs.
- Hit: 0 added cycles; stall_m never rises.
- Miss with memory latency N (done N cycles after acceptance): stall_m is high for N cycles, then low in the done cycle.
- Each cycle mem_stall is high before acceptance adds one stall cycle.
- Timeout: stall_m is high for exactly TIMEOUT cycles; timeout_err pulses in the cycle after the last stalled cycle.
- All outputs are combinational from state and inputs; there are no registered output delays.
- Back-to-back accesses: a new request may be issued in the cycle immediately after a done cycle.

## Test plan
- Aligned load to 0x0010 with mem_done in the same cycle and mem_data_out = 0xBEEF -> mem_rd = 1 for one cycle, readData = 0xBEEF, stall_m never asserted.
- Store to 0x0020 with mem_done 3 cycles after acceptance -> mem_wr high only in the request cycle, stall_m high for 3 cycles, busy high for 3 cycles, readData = 0.
- Load to 0x0021 -> no mem_rd, align_err_m = 1, stall_m = 0, readData = 0.
- Load with mem_stall high for 2 cycles, then accepted with done after 1 cycle -> mem_rd high for 3 cycles, stall_m high for 3 cycles, correct data returned.
- Load with TIMEOUT = 4 and no mem_done -> stall_m high for 4 cycles, then timeout_err pulses for 1 cycle, state returns to IDLE.
- rst asserted mid-BUSY -> busy, stall_m and cnt clear immediately; the next request is issued fresh from IDLE.
